// File: rtl/led_bar_pkg.sv
// Shared encodings for the LED bar-graph gauge and its helper blocks.
package led_bar_pkg;

  typedef enum logic [1:0] {
    MODE_BAR = 2'd0,
    MODE_DOT = 2'd1,
    MODE_CZ  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam int unsigned OUT_UNDER = 0;
  localparam int unsigned OUT_OVER  = 1;

endpackage

// File: rtl/led_blink_timer.sv
// Free-running on/off phase generator for blinking indicators; parked in the on phase when idle.
module led_blink_timer #(
  parameter int unsigned C_ON   = 2,
  parameter int unsigned C_OFF  = 3,
  parameter int unsigned C_BITS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_on
);

  localparam logic [C_BITS-1:0] LAST = C_BITS'(C_ON + C_OFF - 1);

  logic [C_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign phase_on = (cnt_q < C_BITS'(C_ON));

endmodule

// File: rtl/led_bar_gauge.sv
// LED bar-graph driver: sequential threshold scan, bar/dot/centre-zero rendering,
// decaying peak marker and blinking range indicators.
module led_bar_gauge
  import led_bar_pkg::*;
#(
  parameter int unsigned LEDS      = 8,
  parameter int unsigned LEDS_BITS = 4,
  parameter int unsigned VAL_BITS  = 8,
  parameter int unsigned VAL_L     = 16,
  parameter int unsigned VAL_STEP  = 24,
  parameter int unsigned ZERO_IDX  = 4,
  parameter int unsigned C_ON      = 2,
  parameter int unsigned C_OFF     = 3,
  parameter int unsigned C_BITS    = 3,
  parameter int unsigned PEAK_HOLD = 10,
  parameter int unsigned PEAK_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [VAL_BITS-1:0] value,
  input  logic [1:0]          mode,
  input  logic                blink,
  output logic [LEDS-1:0]     in_en,
  output logic [1:0]          out_en,
  output logic                busy
);

  localparam int unsigned VAL_U = VAL_L + LEDS * VAL_STEP - 1;

  state_e                 state_q, state_d;
  logic [VAL_BITS-1:0]    val_q, val_d;
  logic [1:0]             mode_q, mode_d, disp_mode_q, disp_mode_d;
  logic [VAL_BITS:0]      thr_q, thr_d;
  logic [LEDS_BITS-1:0]   k_q, k_d, cand_q, cand_d, idx_q, idx_d, peak_q, peak_d;
  logic [PEAK_BITS-1:0]   ptmr_q, ptmr_d;
  logic                   under_q, under_d, over_q, over_d, valid_q, valid_d, busy_q, busy_d;
  logic [LEDS-1:0]        pat_q, pat_d, mark, in_en_q, in_en_d;
  logic [1:0]             out_en_q, out_en_d;
  logic                   phase_on, blink_run, blink_clr;

  function automatic logic [LEDS-1:0] render(input logic [LEDS_BITS-1:0] idx,
                                             input logic [1:0] m);
    logic [LEDS-1:0]      p;
    logic [LEDS_BITS-1:0] zero, lo, hi;
    zero = LEDS_BITS'(ZERO_IDX);
    lo   = (idx < zero) ? idx : zero;
    hi   = (idx < zero) ? zero : idx;
    p    = '0;
    for (int unsigned i = 0; i < LEDS; i++) begin
      case (m)
        MODE_DOT: p[i] = (LEDS_BITS'(i) == idx);
        MODE_CZ:  p[i] = (LEDS_BITS'(i) >= lo) && (LEDS_BITS'(i) <= hi);
        default:  p[i] = (LEDS_BITS'(i) <= idx);
      endcase
    end
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    k_d         = k_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    under_d     = under_q;
    over_d      = over_q;
    disp_mode_d = disp_mode_q;
    pat_d       = pat_q;
    valid_d     = valid_q;
    peak_d      = peak_q;
    ptmr_d      = ptmr_q;

    case (state_q)
      IDLE: begin
        val_d   = value;
        mode_d  = mode;
        thr_d   = (VAL_BITS+1)'(VAL_L);
        k_d     = '0;
        cand_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if ({1'b0, val_q} >= thr_q) cand_d = k_q;
        thr_d = thr_q + (VAL_BITS+1)'(VAL_STEP);
        k_d   = k_q + 1'b1;
        if (k_q == LEDS_BITS'(LEDS - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        under_d     = (32'(val_q) < VAL_L);
        over_d      = (32'(val_q) > VAL_U);
        idx_d       = under_d ? '0 : (over_d ? LEDS_BITS'(LEDS - 1) : cand_q);
        disp_mode_d = mode_q;
        pat_d       = render(idx_d, mode_q);
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Between updates idx_d == idx_q, so this single rule covers both the
    // commit-time capture and the per-cycle hold/decay of the peak.
    if (disp_mode_d == MODE_CZ || idx_d >= peak_q) begin
      peak_d = idx_d;
      ptmr_d = '0;
    end else if (ptmr_q == PEAK_BITS'(PEAK_HOLD - 1)) begin
      peak_d = peak_q - 1'b1;
      ptmr_d = '0;
    end else begin
      ptmr_d = ptmr_q + 1'b1;
    end

    mark = '0;
    for (int unsigned i = 0; i < LEDS; i++)
      mark[i] = valid_d && (disp_mode_d != MODE_CZ) && (LEDS_BITS'(i) == peak_d);

    in_en_d             = (pat_d | mark) & (blink ? {LEDS{phase_on}} : '1);
    out_en_d            = '0;
    out_en_d[OUT_UNDER] = under_d & phase_on;
    out_en_d[OUT_OVER]  = over_d & phase_on;
    busy_d              = (state_d == SCAN);
  end

  assign blink_run = blink | under_d | over_d;
  assign blink_clr = reset | ~en;

  led_blink_timer #(
    .C_ON   (C_ON),
    .C_OFF  (C_OFF),
    .C_BITS (C_BITS)
  ) u_blink (
    .clk      (clk),
    .reset    (blink_clr),
    .run      (blink_run),
    .phase_on (phase_on)
  );

  // Dropping en clears the whole display state exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state_q     <= IDLE;
      val_q       <= '0;
      mode_q      <= '0;
      thr_q       <= '0;
      k_q         <= '0;
      cand_q      <= '0;
      idx_q       <= '0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      disp_mode_q <= '0;
      pat_q       <= '0;
      valid_q     <= 1'b0;
      peak_q      <= '0;
      ptmr_q      <= '0;
      in_en_q     <= '0;
      out_en_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      k_q         <= k_d;
      cand_q      <= cand_d;
      idx_q       <= idx_d;
      under_q     <= under_d;
      over_q      <= over_d;
      disp_mode_q <= disp_mode_d;
      pat_q       <= pat_d;
      valid_q     <= valid_d;
      peak_q      <= peak_d;
      ptmr_q      <= ptmr_d;
      in_en_q     <= in_en_d;
      out_en_q    <= out_en_d;
      busy_q      <= busy_d;
    end
  end

  assign in_en  = in_en_q;
  assign out_en = out_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_led_bar_gauge.sv
// Scoreboard bench for led_bar_gauge: directed stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_led_bar_gauge;

  logic       clk = 1'b0;
  logic       reset, en, blink;
  logic [7:0] value;
  logic [1:0] mode;
  logic [7:0] in_en;
  logic [1:0] out_en;
  logic       busy;

  typedef struct {
    string      name;
    int         tag;
    logic [7:0] in_en;
    logic [1:0] out_en;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  led_bar_gauge #(
    .LEDS(8), .LEDS_BITS(4), .VAL_BITS(8), .VAL_L(16), .VAL_STEP(24), .ZERO_IDX(4),
    .C_ON(2), .C_OFF(3), .C_BITS(3), .PEAK_HOLD(10), .PEAK_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .mode(mode), .blink(blink),
    .in_en(in_en), .out_en(out_en), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_at(input string name, input int tag, input logic [7:0] ie,
                        input logic [1:0] oe, input logic b);
    exp_t e;
    e.name = name; e.tag = tag; e.in_en = ie; e.out_en = oe; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      e = exp_q.pop_front();
      n_check++;
      if (e.tag != cyc || in_en !== e.in_en || out_en !== e.out_en || busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s @cycle %0d (due %0d): got in_en=%h out_en=%b busy=%b, want in_en=%h out_en=%b busy=%b",
                 e.name, cyc, e.tag, in_en, out_en, busy, e.in_en, e.out_en, e.busy);
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; value = '0; mode = '0; blink = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    chk_at("reset_state", 2, 8'h00, 2'b00, 1'b0);
    chk_at("idle_en_low", 3, 8'h00, 2'b00, 1'b0);

    // Bar, value 100 -> idx 3
    wait_cyc(3);
    en = 1'b1; value = 8'd100; mode = 2'd0;
    chk_at("bar_busy_first", 4, 8'h00, 2'b00, 1'b1);
    chk_at("bar_busy_last", 11, 8'h00, 2'b00, 1'b1);
    chk_at("bar_busy_drop", 12, 8'h00, 2'b00, 1'b0);
    chk_at("bar_100", 13, 8'h0F, 2'b00, 1'b0);
    chk_at("bar_resample", 14, 8'h0F, 2'b00, 1'b1);
    wait_cyc(14);
    mode = 2'd2;
    chk_at("bar_repeat", 23, 8'h0F, 2'b00, 1'b0);
    chk_at("cz_pending", 32, 8'h0F, 2'b00, 1'b0);
    chk_at("cz_100", 33, 8'h18, 2'b00, 1'b0);
    wait_cyc(24);
    value = 8'd180;
    chk_at("cz_180", 43, 8'h70, 2'b00, 1'b0);
    chk_at("cz_resample", 44, 8'h70, 2'b00, 1'b1);
    wait_cyc(44);
    en = 1'b0;
    chk_at("abort_scan1", 45, 8'h00, 2'b00, 1'b0);

    // Over-range: full bar, over flag blinks 2 on / 3 off
    wait_cyc(45);
    en = 1'b1; value = 8'd220; mode = 2'd0;
    for (int t = 55; t <= 64; t++)
      chk_at("over_blink", t, 8'hFF, ((t - 55) % 5 < 2) ? 2'b10 : 2'b00, (t >= 56 && t <= 63));
    wait_cyc(65);
    en = 1'b0;
    chk_at("abort_over", 66, 8'h00, 2'b00, 1'b0);

    // Under-range: LED 0, under flag blinks
    wait_cyc(66);
    en = 1'b1; value = 8'd10;
    for (int t = 76; t <= 85; t++)
      chk_at("under_blink", t, 8'h01, ((t - 76) % 5 < 2) ? 2'b01 : 2'b00, (t >= 77 && t <= 84));
    wait_cyc(86);
    en = 1'b0;
    chk_at("abort_under", 87, 8'h00, 2'b00, 1'b0);

    // Dot with peak hold and decay
    wait_cyc(87);
    en = 1'b1; value = 8'd200; mode = 2'd1;
    chk_at("dot_200", 97, 8'h80, 2'b00, 1'b0);
    wait_cyc(88);
    value = 8'd40;
    chk_at("dot_peak7", 107, 8'h82, 2'b00, 1'b0);
    chk_at("peak7_hold", 115, 8'h82, 2'b00, 1'b1);
    chk_at("peak6", 116, 8'h42, 2'b00, 1'b0);
    chk_at("peak5", 126, 8'h22, 2'b00, 1'b0);
    chk_at("peak4", 136, 8'h12, 2'b00, 1'b0);
    chk_at("peak3", 146, 8'h0A, 2'b00, 1'b0);
    chk_at("peak3_hold", 155, 8'h0A, 2'b00, 1'b1);
    chk_at("peak2", 156, 8'h06, 2'b00, 1'b0);
    chk_at("peak1", 166, 8'h02, 2'b00, 1'b0);
    chk_at("peak_settled", 176, 8'h02, 2'b00, 1'b0);
    wait_cyc(176);
    en = 1'b0;
    chk_at("abort_dot", 177, 8'h00, 2'b00, 1'b0);

    // Blink gating of in-range LEDs
    wait_cyc(177);
    en = 1'b1; value = 8'd100; mode = 2'd0;
    chk_at("blink_pre", 187, 8'h0F, 2'b00, 1'b0);
    wait_cyc(189);
    blink = 1'b1;
    for (int t = 190; t <= 199; t++)
      chk_at("blink_on", t, ((t - 190) % 5 < 2) ? 8'h0F : 8'h00, 2'b00, (t <= 195 || t >= 198));
    wait_cyc(199);
    blink = 1'b0;
    chk_at("blink_off_a", 200, 8'h0F, 2'b00, 1'b1);
    chk_at("blink_off_b", 201, 8'h0F, 2'b00, 1'b1);

    // Reset mid-scan, then a fresh scan
    wait_cyc(201);
    reset = 1'b1;
    chk_at("reset_scan", 202, 8'h00, 2'b00, 1'b0);
    wait_cyc(202);
    reset = 1'b0;
    chk_at("rescan_first", 203, 8'h00, 2'b00, 1'b1);
    chk_at("rescan_last", 210, 8'h00, 2'b00, 1'b1);
    chk_at("rescan_drop", 211, 8'h00, 2'b00, 1'b0);
    chk_at("rescan_out", 212, 8'h0F, 2'b00, 1'b0);
    chk_at("scan4_busy", 216, 8'h0F, 2'b00, 1'b1);

    // en drop at scan cycle 4, then restart
    wait_cyc(216);
    en = 1'b0;
    chk_at("abort_scan4", 217, 8'h00, 2'b00, 1'b0);
    wait_cyc(217);
    en = 1'b1;
    chk_at("restart_first", 218, 8'h00, 2'b00, 1'b1);
    chk_at("restart_last", 225, 8'h00, 2'b00, 1'b1);
    chk_at("restart_drop", 226, 8'h00, 2'b00, 1'b0);
    chk_at("restart_out", 227, 8'h0F, 2'b00, 1'b0);

    wait_cyc(230);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_check++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/led_bar_gauge.md
Name: led_bar_gauge

Overview:
- Parametrised next-generation LED bar-graph driver for the gauge display.
- Samples a value, quantises it to an LED index with a sequential threshold scan, and renders one of three modes: bar, dot or centre-zero bar.
- Adds a peak-hold marker with timed decay, plus blinking under/over-range indicators.
- Sits between the sensor/scaling logic and the LED pin drivers; one instance per gauge.

Parameters:
- LEDS, 8: number of in-range LEDs.
- LEDS_BITS, 4: width of the LED index and scan counter; must satisfy 2^LEDS_BITS > LEDS.
- VAL_BITS, 8: width of the value input (unsigned).
- VAL_L, 16: lowest in-range value.
- VAL_STEP, 24: value span per LED. Derived constant VAL_U = VAL_L + LEDS*VAL_STEP - 1.
- ZERO_IDX, 4: LED index of the zero point in centre-zero mode.
- C_ON, 2: blink on-phase length in cycles.
- C_OFF, 3: blink off-phase length in cycles.
- C_BITS, 3: blink counter width; must hold C_ON+C_OFF-1.
- PEAK_HOLD, 10: cycles per peak decay step.
- PEAK_BITS, 4: peak timer width.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- en  in  1  display enable.
- value  in  VAL_BITS  value to display.
- mode  in  2  display mode: 0 bar, 1 dot, 2 centre-zero; 3 is treated as 0.
- blink  in  1  blink all in-range LEDs.
- in_en  out  LEDS  in-range LED drives.
- out_en  out  2  range LEDs: [0] under-range, [1] over-range.
- busy  out  1  a scan is in progress.

Behaviour:
- Reset: in_en=0, out_en=0, busy=0, FSM=IDLE, idx=0, peak=0, all counters 0.
- FSM IDLE -> SCAN: taken on a clk edge with en=1. That edge latches value and mode, sets thr=VAL_L and k=0.
- SCAN: lasts exactly LEDS cycles. Each cycle: if latched value >= thr then cand=k; then thr += VAL_STEP and k++. After k=LEDS-1 the FSM goes to UPDATE. busy=1 throughout SCAN.
- UPDATE: lasts one cycle. Commits idx and the range flags, updates peak, registers the outputs, then returns to IDLE. If en is still 1, the next sample is taken on the following edge.
- Latency: sample at edge E; outputs change at edge E+LEDS+1. Changes to value or mode during SCAN/UPDATE are ignored.
- Range flags:
  - under = value < VAL_L; idx is forced to 0.
  - over = value > VAL_U; idx is forced to LEDS-1.
  - Thresholds use VAL_BITS+1 bits so they never wrap.
- Pattern by mode:
  - bar: LEDs 0..idx lit.
  - dot: only LED idx lit.
  - centre-zero: LEDs from min(idx,ZERO_IDX) to max(idx,ZERO_IDX) lit.
- Peak (bar/dot modes only):
  - At UPDATE, if idx >= peak: peak=idx and the peak timer clears.
  - Otherwise the timer counts every cycle. On reaching PEAK_HOLD-1, if peak > idx then peak decrements and the timer clears.
  - in_en[peak] is forced to 1.
  - In centre-zero mode, peak tracks idx and adds no marker.
- Blink phase counter:
  - Runs while blink=1 or under or over.
  - Phase is on for counts 0..C_ON-1 and off for C_ON..C_ON+C_OFF-1, then wraps to 0.
  - Held at 0 (on phase) otherwise.
- Output gating:
  - in_en = pattern AND (blink ? phase_on : 1).
  - out_en[0] = under AND phase_on; out_en[1] = over AND phase_on.
- en=0: aborts any scan in the next cycle. The FSM goes to IDLE; in_en, out_en, busy, peak and the counters go to 0.
- reset=1 mid-scan: same as the reset state on that edge; reset has priority over en.

Decomposition:
- Shared package (led_bar_pkg):
  - mode encodings MODE_BAR, MODE_DOT, MODE_CZ;
  - FSM state encodings IDLE, SCAN, UPDATE;
  - out_en bit indices OUT_UNDER, OUT_OVER.
- Sub-module led_blink_timer (C_ON, C_OFF, C_BITS; ports clk, reset, run, phase_on). It is reusable by other indicators.
- The scan FSM, peak logic and pattern logic stay in led_bar_gauge.

Test Plan:
- Default params, en=1, mode=0, value=100 -> busy high 8 cycles; at E+9 in_en=8'b0000_1111, out_en=0.
- mode=2, value=100 -> in_en=8'b0001_1000. Then value=180 (idx 6) -> in_en=8'b0111_0000.
- mode=0, value=220 -> in_en=8'hFF, out_en[1] toggles 2 cycles on / 3 off. Then value=10 -> in_en=8'b0000_0001 and out_en[0] blinks with the same phase.
- mode=1, value=200 then value=40 (idx 1) -> in_en=8'b1000_0010. Thereafter the peak bit steps down by one every 10 cycles until the display is 8'b0000_0010.
- blink=1, value=100, mode=0 -> in_en alternates 8'h0F for 2 cycles and 8'h00 for 3 cycles. blink=0 -> steady 8'h0F.
- Drop en to 0 at scan cycle 4, and separately assert reset during SCAN -> next edge shows busy=0, all outputs 0, peak 0. Re-raising en produces a fresh 8-cycle scan.
